// File: rtl/delay_line_ctrl.sv
// Sample delay line over an external sync-read RAM: write, read back, capture, hold.
// Latency 3 cycles accept->m_valid; one sample in flight; s_ready only when idle. Optional mix: DELAY_MIX_EN.
module delay_line_ctrl #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic [DATA_W-1:0] s_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] delay,
  output logic [DATA_W-1:0] m_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, OUT} state_t;

  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [ADDR_W-1:0]   dly_q, dly_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [DATA_W-1:0]   m_out_q, m_out_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   delayed;
  logic [DATA_W-1:0]   result;

  // Words not yet written since reset read as zero, whatever the RAM holds.
  always_comb begin
    delayed = ram_out;
    if ({1'b0, dly_q} >= fill_q) delayed = '0;
  end

`ifdef DELAY_MIX_EN
  logic signed [DATA_W:0] mix_sum;
  always_comb begin
    mix_sum = $signed({sample_q[DATA_W-1], sample_q}) + $signed({delayed[DATA_W-1], delayed});
    result  = mix_sum[DATA_W:1];
  end
`else
  assign result = delayed;
`endif

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    dly_d     = dly_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    m_out_d   = m_out_q;
    m_valid_d = m_valid_q;
    s_ready   = 1'b0;
    ram_wren  = 1'b0;
    ram_addr  = '0;
    ram_in    = '0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sample_d = s_in;
          dly_d    = delay;
          state_d  = WR;
        end
      end
      WR: begin
        ram_wren = 1'b1;
        ram_addr = wr_ptr_q;
        ram_in   = sample_q;
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
        state_d  = RD;
      end
      RD: begin
        // Same address as the write when dly_q is 0, so the fresh sample reads back.
        ram_addr = wr_ptr_q - dly_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = CAP;
      end
      CAP: begin
        m_out_d   = result;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      dly_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      m_out_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      dly_q     <= dly_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      m_out_q   <= m_out_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_out   = m_out_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl with a behavioural sync-read RAM.
module tb_delay_line_ctrl;
  localparam int DW = 18;
  localparam int AW = 12;
`ifdef DELAY_MIX_EN
  localparam bit MIX = 1'b1;
`else
  localparam bit MIX = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aclr_n = 1'b0;
  logic [DW-1:0] s_in = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] delay = '0;
  logic [DW-1:0] m_out;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] ram_in;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_out;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  delay_line_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .aclr_n(aclr_n), .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready),
    .delay(delay), .m_out(m_out), .m_valid(m_valid), .m_ready(m_ready),
    .ram_in(ram_in), .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_out(ram_out)
  );

  // RAM preloaded with junk so reads of unwritten words would be visible.
  logic [DW-1:0] mem [0:4095];
  logic [AW-1:0] raddr_q = '0;
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 18'h2AAAA;
      mem_init <= 1'b1;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_in;
    end
    raddr_q <= ram_addr;
  end
  assign ram_out = mem[raddr_q];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] pick(input logic [DW-1:0] off, input logic [DW-1:0] on);
    return MIX ? on : off;
  endfunction

  // Monitor: every output handshake pops one expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (aclr_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", {14'd0, m_out}, 32'hFFFF_FFFF);
        else check("m_out", {14'd0, m_out}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [DW-1:0] v, input logic [AW-1:0] d, input logic [DW-1:0] e,
                      input bit push, input bit lat);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    s_in = v;
    delay = d;
    s_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    s_valid = 1'b0;
    delay = ~d;
    if (lat) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("lat_cycle2_m_valid", {31'd0, m_valid}, 0);
      @(posedge clk); #1;
      check("lat_cycle3_m_valid", {31'd0, m_valid}, 1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    aclr_n = 1'b0;
    @(posedge clk); #1;
    aclr_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    int n;
    int d;
    int e;

    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 1);
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_out", {14'd0, m_out}, 0);
    check("rst_ram_wren", {31'd0, ram_wren}, 0);
    check("rst_ram_addr", {20'd0, ram_addr}, 0);
    check("rst_ram_in", {14'd0, ram_in}, 0);
    aclr_n = 1'b1;

    send(18'd100, 12'd0, pick(18'd100, 18'd100), 1'b1, 1'b1);
    wait_drain();

    do_reset();
    send(18'd10, 12'd2, pick(18'd0,  18'd5),  1'b1, 1'b1);
    send(18'd20, 12'd2, pick(18'd0,  18'd10), 1'b1, 1'b0);
    send(18'd30, 12'd2, pick(18'd10, 18'd20), 1'b1, 1'b0);
    send(18'd40, 12'd2, pick(18'd20, 18'd30), 1'b1, 1'b0);
    wait_drain();

    // Backpressure: output held for 5 cycles.
    @(posedge clk); #1;
    m_ready = 1'b0;
    send(18'd77, 12'd0, 18'd77, 1'b1, 1'b0);
    n = 0;
    while (!m_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_m_valid_seen", {31'd0, m_valid}, 1);
    held = m_out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_m_valid", {31'd0, m_valid}, 1);
      check("hold_m_out", {14'd0, m_out}, {14'd0, held});
      check("hold_s_ready", {31'd0, s_ready}, 0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_s_ready", {31'd0, s_ready}, 1);
    check("post_hs_m_valid", {31'd0, m_valid}, 0);
    wait_drain();

    // Reset while in RD: the in-flight sample is dropped.
    send(18'd55, 12'd1, 18'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_rd_wren", {31'd0, ram_wren}, 0);
    #1;
    aclr_n = 1'b0;
    #1;
    check("rd_rst_m_valid", {31'd0, m_valid}, 0);
    check("rd_rst_m_out", {14'd0, m_out}, 0);
    check("rd_rst_ram_addr", {20'd0, ram_addr}, 0);
    check("rd_rst_ram_in", {14'd0, ram_in}, 0);
    check("rd_rst_ram_wren", {31'd0, ram_wren}, 0);
    check("rd_rst_s_ready", {31'd0, s_ready}, 1);
    @(posedge clk); #1;
    aclr_n = 1'b1;
    send(18'd55, 12'd1, pick(18'd0, 18'd27), 1'b1, 1'b1);
    wait_drain();

    send(18'h1FFFF, 12'd0, 18'h1FFFF, 1'b1, 1'b0);
    send(18'h20000, 12'd0, 18'h20000, 1'b1, 1'b0);
    wait_drain();

    // Full-depth wrap: 4097 samples of value n, delay 4095.
    do_reset();
    for (int k = 0; k <= 4096; k++) begin
      d = (k >= 4095) ? k - 4095 : 0;
      e = MIX ? ((k + d) >> 1) : d;
      send(DW'(k), 12'd4095, DW'(e), 1'b1, 1'b0);
    end
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
